// File: rtl/modinv_helper_xfer.sv
// Operand-transfer helper: streams one multi-word operand from the scratch buffer into any
// subset of destination operand memories, applying copy/clear/load-one/shift-left-1 on the way.
module modinv_helper_xfer #(
    parameter int unsigned OPERAND_NUM_WORDS = 8,
    parameter int unsigned OPERAND_ADDR_BITS = 3,
    parameter int unsigned BUFFER_NUM_WORDS  = 9,
    parameter int unsigned BUFFER_ADDR_BITS  = 4,
    parameter int unsigned DST_NUM           = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    output logic                         rdy,
    input  logic [1:0]                   mode,
    input  logic [BUFFER_ADDR_BITS-1:0]  s_offset,
    input  logic [DST_NUM-1:0]           dst_mask,
    output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
    input  logic [31:0]                  s_din,
    output logic [OPERAND_ADDR_BITS-1:0] d_addr,
    output logic [DST_NUM-1:0]           d_wren,
    output logic [31:0]                  d_dout,
    output logic                         carry_out
);

    localparam int unsigned     CntW    = $clog2(OPERAND_NUM_WORDS + 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(OPERAND_NUM_WORDS + 1);
    localparam logic [CntW-1:0] FirstWr = CntW'(2);

    typedef enum logic [1:0] {
        ModeCopy    = 2'b00,
        ModeClear   = 2'b01,
        ModeLoadOne = 2'b10,
        ModeShift   = 2'b11
    } mode_e;

    logic [CntW-1:0]             r_cnt,    w_cnt_nxt;
    mode_e                       r_mode,   w_mode_nxt;
    logic [BUFFER_ADDR_BITS-1:0] r_offset, w_offset_nxt;
    logic [DST_NUM-1:0]          r_mask,   w_mask_nxt;
    logic                        r_c,      w_c_nxt;
    logic                        r_carry,  w_carry_nxt;

    logic                        w_idle;
    logic                        w_wr_phase;

    assign w_idle     = (r_cnt == '0);
    assign w_wr_phase = (r_cnt >= FirstWr);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mode   <= ModeCopy;
            r_offset <= '0;
            r_mask   <= '0;
            r_c      <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_mode   <= w_mode_nxt;
            r_offset <= w_offset_nxt;
            r_mask   <= w_mask_nxt;
            r_c      <= w_c_nxt;
            r_carry  <= w_carry_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_mode_nxt   = r_mode;
        w_offset_nxt = r_offset;
        w_mask_nxt   = r_mask;
        w_c_nxt      = r_c;
        w_carry_nxt  = r_carry;
        if (w_idle) begin
            if (ena) begin
                w_cnt_nxt    = CntW'(1);
                w_mode_nxt   = mode_e'(mode);
                w_offset_nxt = s_offset;
                w_mask_nxt   = dst_mask;
                w_c_nxt      = 1'b0;
            end
        end else begin
            w_cnt_nxt = (r_cnt == LastCnt) ? '0 : r_cnt + CntW'(1);
            // Carry chain advances once per written word; the last word's MSB leaves the block.
            if (w_wr_phase && (r_mode == ModeShift)) begin
                w_c_nxt = s_din[31];
                if (r_cnt == LastCnt) begin
                    w_carry_nxt = s_din[31];
                end
            end
        end
    end

    // Output decode
    always_comb begin
        rdy       = w_idle;
        carry_out = r_carry;
        s_addr    = r_offset;
        d_addr    = '0;
        d_wren    = '0;
        d_dout    = 32'h0;
        if (!w_idle) begin
            s_addr = r_offset + BUFFER_ADDR_BITS'(r_cnt - CntW'(1));
        end
        if (w_wr_phase) begin
            d_addr = OPERAND_ADDR_BITS'(r_cnt - FirstWr);
            d_wren = r_mask;
            unique case (r_mode)
                ModeCopy:    d_dout = s_din;
                ModeClear:   d_dout = 32'h0;
                ModeLoadOne: d_dout = (r_cnt == FirstWr) ? 32'h1 : 32'h0;
                ModeShift:   d_dout = {s_din[30:0], r_c};
                default:     d_dout = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_helper_xfer.sv
// Directed bench for modinv_helper_xfer with a synchronous buffer model and two destination
// memories; expected words are hand-derived from the buffer patterns.
module tb_modinv_helper_xfer;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        rdy;
    logic [1:0]  mode;
    logic [3:0]  s_offset;
    logic [1:0]  dst_mask;
    logic [3:0]  s_addr;
    logic [31:0] s_din;
    logic [2:0]  d_addr;
    logic [1:0]  d_wren;
    logic [31:0] d_dout;
    logic        carry_out;

    logic        pat;
    logic        fill;
    logic [31:0] dst0 [0:7];
    logic [31:0] dst1 [0:7];
    logic [3:0]  saddr_log [0:39];

    int n_chk;
    int n_err;
    int busy;

    modinv_helper_xfer #(
        .OPERAND_NUM_WORDS(8),
        .OPERAND_ADDR_BITS(3),
        .BUFFER_NUM_WORDS (9),
        .BUFFER_ADDR_BITS (4),
        .DST_NUM          (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .rdy      (rdy),
        .mode     (mode),
        .s_offset (s_offset),
        .dst_mask (dst_mask),
        .s_addr   (s_addr),
        .s_din    (s_din),
        .d_addr   (d_addr),
        .d_wren   (d_wren),
        .d_dout   (d_dout),
        .carry_out(carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer: word i holds A000_0000+i, or 8000_0001 everywhere when pat is set
    always @(posedge clk) begin
        s_din <= pat ? 32'h8000_0001 : 32'hA000_0000 + {28'h0, s_addr};
    end

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 8; i++) begin
                dst0[i] <= 32'hDEAD_BEEF;
                dst1[i] <= 32'hDEAD_BEEF;
            end
        end else begin
            if (d_wren[0]) dst0[d_addr] <= d_dout;
            if (d_wren[1]) dst1[d_addr] <= d_dout;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] m, input logic [3:0] off, input logic [1:0] msk,
                        output int cyc);
        @(negedge clk);
        mode     = m;
        s_offset = off;
        dst_mask = msk;
        ena      = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        cyc = 0;
        while (!rdy && cyc < 40) begin
            saddr_log[cyc] = s_addr;
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        ena      = 1'b0;
        mode     = 2'b00;
        s_offset = 4'h0;
        dst_mask = 2'b00;
        pat      = 1'b0;
        fill     = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_rdy", rdy, 1);
        chk("rst_wren", d_wren, 0);
        chk("rst_daddr", d_addr, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_saddr", s_addr, 0);
        fill  = 1'b0;
        rst_n = 1'b1;

        // Plain copy into dst0 only
        xfer(2'b00, 4'd0, 2'b01, busy);
        chk("copy_busy", busy, 9);
        for (int i = 0; i < 8; i++) chk($sformatf("copy_d0_%0d", i), dst0[i], 32'hA000_0000 + i);
        chk("copy_d1_untouched", dst1[0], 32'hDEAD_BEEF);

        // Offset 1, multicast to both
        xfer(2'b00, 4'd1, 2'b11, busy);
        chk("mc_busy", busy, 9);
        chk("mc_saddr_first", saddr_log[0], 1);
        chk("mc_saddr_last", saddr_log[7], 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mc_d0_%0d", i), dst0[i], 32'hA000_0001 + i);
            chk($sformatf("mc_d1_%0d", i), dst1[i], 32'hA000_0001 + i);
        end

        // Clear dst1, then load-one into dst1
        xfer(2'b01, 4'd0, 2'b10, busy);
        for (int i = 0; i < 8; i++) chk($sformatf("clr_d1_%0d", i), dst1[i], 0);
        chk("clr_d0_kept", dst0[0], 32'hA000_0001);
        xfer(2'b10, 4'd0, 2'b10, busy);
        chk("one_d1_0", dst1[0], 1);
        for (int i = 1; i < 8; i++) chk($sformatf("one_d1_%0d", i), dst1[i], 0);

        // Shift-left-1 over 8000_0001 words
        pat = 1'b1;
        xfer(2'b11, 4'd0, 2'b01, busy);
        chk("shl_d0_0", dst0[0], 32'h0000_0002);
        for (int i = 1; i < 8; i++) chk($sformatf("shl_d0_%0d", i), dst0[i], 32'h0000_0003);
        chk("shl_carry", carry_out, 1);

        // A copy must not disturb carry_out
        pat = 1'b0;
        xfer(2'b00, 4'd0, 2'b01, busy);
        chk("copy2_carry_hold", carry_out, 1);
        chk("copy2_d0_5", dst0[5], 32'hA000_0005);

        // ena pulse mid-transfer is ignored
        @(negedge clk);
        mode = 2'b00; s_offset = 4'd1; dst_mask = 2'b10; ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mode = 2'b01; s_offset = 4'd0; dst_mask = 2'b11; ena = 1'b1;
        @(negedge clk);
        ena  = 1'b0;
        busy = 3;
        while (!rdy && busy < 40) begin
            busy++;
            @(negedge clk);
        end
        chk("ign_busy", busy, 9);
        for (int i = 0; i < 8; i++) chk($sformatf("ign_d1_%0d", i), dst1[i], 32'hA000_0001 + i);
        chk("ign_d0_kept", dst0[2], 32'hA000_0002);

        // ena held high: restart on the first idle cycle
        @(negedge clk);
        mode = 2'b01; s_offset = 4'd0; dst_mask = 2'b01; ena = 1'b1;
        @(negedge clk);
        busy = 0;
        while (!rdy && busy < 40) begin
            busy++;
            @(negedge clk);
        end
        chk("b2b_busy1", busy, 9);
        @(negedge clk);
        chk("b2b_restart", rdy, 0);
        ena  = 1'b0;
        busy = 0;
        while (!rdy && busy < 40) begin
            busy++;
            @(negedge clk);
        end
        chk("b2b_busy2", busy, 9);
        chk("b2b_d0_7", dst0[7], 0);

        // Reset lands right after the edge that writes word 3
        fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        mode = 2'b00; s_offset = 4'd0; dst_mask = 2'b01; ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_wren_before", d_wren, 2'b01);
        chk("mid_daddr_before", d_addr, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_wren_after", d_wren, 0);
        chk("mid_rdy_after", rdy, 1);
        chk("mid_daddr_after", d_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_d0_0", dst0[0], 32'hA000_0000);
        chk("mid_d0_3", dst0[3], 32'hA000_0003);
        chk("mid_d0_4", dst0[4], 32'hDEAD_BEEF);
        chk("mid_carry", carry_out, 0);

        xfer(2'b00, 4'd1, 2'b01, busy);
        chk("post_busy", busy, 9);
        chk("post_d0_4", dst0[4], 32'hA000_0005);
        chk("post_d0_7", dst0[7], 32'hA000_0008);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
